// File: rtl/rotate_pkg.sv
// ============================================================================
// rotate_pkg : bank index type and bank helpers shared by the rotator blocks
// Revision   : 1.0
// ============================================================================
`default_nettype none

package rotate_pkg;

  typedef logic [1:0] bank_t;

  localparam bank_t NBANK_MAX = 2'd3;

  // Result is 32 bits wide; callers cast down to their own address width.
  function automatic logic [31:0] bank_base(input bank_t bank, input int unsigned bufsize);
    return 32'(bank) * bufsize;
  endfunction

  function automatic bank_t third_bank(input bank_t a, input bank_t b);
    return NBANK_MAX - a - b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_cnt8.sv
// ============================================================================
// sat_cnt8 : 8-bit event counter that sticks at 255, cleared by sync reset
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_cnt8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_i,
  output logic [7:0] cnt_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/rotate_bank_sched.sv
// ============================================================================
// rotate_bank_sched : picks write/read banks of the rotator frame buffer
// Revision          : 1.0
// ============================================================================
`default_nettype none

module rotate_bank_sched
  import rotate_pkg::*;
#(
  parameter int unsigned BUFSIZE = 76800,
  parameter int unsigned AW      = 18,
  parameter int unsigned TRIPLE  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_frame_start,
  input  logic          rd_frame_start,
  input  logic          freeze,
  output logic [1:0]    wr_bank,
  output logic [1:0]    rd_bank,
  output logic [AW-1:0] wr_base,
  output logic [AW-1:0] rd_base,
  output logic          wr_en_gate,
  output logic          rd_valid,
  output logic [7:0]    drop_cnt,
  output logic [7:0]    repeat_cnt
);

  localparam bank_t         C_WR_RST   = 2'd0;
  localparam bank_t         C_RD_RST   = (TRIPLE != 0) ? 2'd2 : 2'd1;
  localparam logic [AW-1:0] C_RD_BASE0 = AW'(bank_base(C_RD_RST, BUFSIZE));

  bank_t         wr_bank_q, wr_bank_d;
  bank_t         rd_bank_q, rd_bank_d;
  bank_t         ready_bank_q, ready_bank_d;
  logic          ready_valid_q, ready_valid_d;
  logic          started_q, started_d;
  logic          wr_en_q, wr_en_d;
  logic          rd_valid_q, rd_valid_d;
  logic [AW-1:0] wr_base_q, rd_base_q;

  logic  w_publish;
  logic  w_take;
  logic  w_drop_inc;
  logic  w_repeat_inc;
  bank_t w_next_wr;

  assign w_publish = wr_frame_start & started_q;
  assign w_take    = rd_frame_start & ~freeze;

  // Triple mode writes into the bank nobody else owns; legacy mode just flips.
  assign w_next_wr = (TRIPLE != 0) ? third_bank(wr_bank_q, rd_bank_q)
                                   : {1'b0, ~wr_bank_q[0]};

  always_comb begin
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    ready_bank_d  = ready_bank_q;
    ready_valid_d = ready_valid_q;
    started_d     = started_q;
    wr_en_d       = wr_en_q;
    rd_valid_d    = rd_valid_q;
    w_drop_inc    = 1'b0;
    w_repeat_inc  = 1'b0;

    if (wr_frame_start && !started_q) begin
      started_d = 1'b1;
      wr_en_d   = 1'b1;
    end

    if (w_publish) begin
      ready_bank_d  = wr_bank_q;
      ready_valid_d = 1'b1;
      w_drop_inc    = ready_valid_q;
      wr_bank_d     = w_next_wr;
    end

    // A read arriving with a publish grabs the frame just closed.
    if (rd_frame_start) begin
      if (w_take && w_publish) begin
        rd_bank_d     = wr_bank_q;
        ready_valid_d = 1'b0;
        rd_valid_d    = 1'b1;
      end else if (w_take && ready_valid_q) begin
        rd_bank_d     = ready_bank_q;
        ready_valid_d = 1'b0;
        rd_valid_d    = 1'b1;
      end else if (rd_valid_q) begin
        w_repeat_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q     <= C_WR_RST;
      rd_bank_q     <= C_RD_RST;
      ready_bank_q  <= 2'd0;
      ready_valid_q <= 1'b0;
      started_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_valid_q    <= 1'b0;
      wr_base_q     <= '0;
      rd_base_q     <= C_RD_BASE0;
    end else begin
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      ready_bank_q  <= ready_bank_d;
      ready_valid_q <= ready_valid_d;
      started_q     <= started_d;
      wr_en_q       <= wr_en_d;
      rd_valid_q    <= rd_valid_d;
      wr_base_q     <= AW'(bank_base(wr_bank_d, BUFSIZE));
      rd_base_q     <= AW'(bank_base(rd_bank_d, BUFSIZE));
    end
  end

  sat_cnt8 u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (w_drop_inc),
    .cnt_o (drop_cnt)
  );

  sat_cnt8 u_repeat_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (w_repeat_inc),
    .cnt_o (repeat_cnt)
  );

  assign wr_bank    = wr_bank_q;
  assign rd_bank    = rd_bank_q;
  assign wr_base    = wr_base_q;
  assign rd_base    = rd_base_q;
  assign wr_en_gate = wr_en_q;
  assign rd_valid   = rd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_rotate_bank_sched.sv
// ============================================================================
// tb_rotate_bank_sched : directed self-checking bench for rotate_bank_sched
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_rotate_bank_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_frame_start = 1'b0;
  logic        rd_frame_start = 1'b0;
  logic        freeze = 1'b0;
  logic [1:0]  wr_bank;
  logic [1:0]  rd_bank;
  logic [17:0] wr_base;
  logic [17:0] rd_base;
  logic        wr_en_gate;
  logic        rd_valid;
  logic [7:0]  drop_cnt;
  logic [7:0]  repeat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rotate_bank_sched #(.BUFSIZE(76800), .AW(18), .TRIPLE(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_frame_start (wr_frame_start),
    .rd_frame_start (rd_frame_start),
    .freeze         (freeze),
    .wr_bank        (wr_bank),
    .rd_bank        (rd_bank),
    .wr_base        (wr_base),
    .rd_base        (rd_base),
    .wr_en_gate     (wr_en_gate),
    .rd_valid       (rd_valid),
    .drop_cnt       (drop_cnt),
    .repeat_cnt     (repeat_cnt)
  );

  // Banks must never collide, and bank 3 must never appear.
  always @(negedge clk) begin
    checks++;
    if (wr_bank === rd_bank || wr_bank === 2'd3 || rd_bank === 2'd3) begin
      errors++;
      $display("FAIL invariant t=%0t wr_bank=%0d rd_bank=%0d", $time, wr_bank, rd_bank);
    end
  end

  task automatic step(input logic w, input logic r);
    wr_frame_start = w;
    rd_frame_start = r;
    @(posedge clk);
    #1;
    wr_frame_start = 1'b0;
    rd_frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (wr_bank !== 2'd0 || rd_bank !== 2'd2 || wr_base !== 18'd0 || rd_base !== 18'd153600 ||
        wr_en_gate !== 1'b0 || rd_valid !== 1'b0 || drop_cnt !== 8'd0 || repeat_cnt !== 8'd0) begin
      errors++;
      $display("FAIL %s got wr=%0d rd=%0d wbase=%0d rbase=%0d gate=%b rv=%b drop=%0d rep=%0d required 0 2 0 153600 0 0 0 0",
               tag, wr_bank, rd_bank, wr_base, rd_base, wr_en_gate, rd_valid, drop_cnt, repeat_cnt);
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    check_reset_outputs("reset_state");
    step(1'b1, 1'b0);
    checks++;
    if (wr_en_gate !== 1'b1 || wr_bank !== 2'd0 || rd_valid !== 1'b0 || rd_base !== 18'd153600) begin
      errors++;
      $display("FAIL first_wr got gate=%b wr=%0d rv=%b rbase=%0d required 1 0 0 153600",
               wr_en_gate, wr_bank, rd_valid, rd_base);
    end
    // Nothing published yet, so a read pulse must not switch banks.
    step(1'b0, 1'b1);
    checks++;
    if (rd_bank !== 2'd2 || rd_valid !== 1'b0 || repeat_cnt !== 8'd0) begin
      errors++;
      $display("FAIL no_publish_read got rd=%0d rv=%b rep=%0d required 2 0 0", rd_bank, rd_valid, repeat_cnt);
    end
  endtask

  task automatic test_steady();
    logic [1:0] exp_wr [6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    logic [1:0] exp_rd [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    for (int f = 0; f < 6; f++) begin
      step(1'b1, 1'b0);
      checks++;
      if (wr_bank !== exp_wr[f] || wr_base !== 18'(76800 * int'(exp_wr[f]))) begin
        errors++;
        $display("FAIL steady_wr[%0d] got wr=%0d wbase=%0d required %0d", f, wr_bank, wr_base, exp_wr[f]);
      end
      idle(4);
      step(1'b0, 1'b1);
      checks++;
      if (rd_bank !== exp_rd[f] || rd_valid !== 1'b1 || rd_base !== 18'(76800 * int'(exp_rd[f]))) begin
        errors++;
        $display("FAIL steady_rd[%0d] got rd=%0d rv=%b rbase=%0d required %0d 1",
                 f, rd_bank, rd_valid, rd_base, exp_rd[f]);
      end
      idle(4);
    end
    checks++;
    if (drop_cnt !== 8'd0 || repeat_cnt !== 8'd0) begin
      errors++;
      $display("FAIL steady_counts got drop=%0d rep=%0d required 0 0", drop_cnt, repeat_cnt);
    end
  endtask

  // Each group is 6 writes and 5 reads; the leading double write drops one frame.
  task automatic test_fast_input();
    for (int g = 0; g < 5; g++) begin
      step(1'b1, 1'b0);
      idle(2);
      for (int k = 0; k < 5; k++) begin
        step(1'b1, 1'b0);
        idle(1);
        step(1'b0, 1'b1);
        idle(1);
      end
    end
    checks++;
    if (drop_cnt !== 8'd5 || repeat_cnt !== 8'd0 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL fast_input got drop=%0d rep=%0d rv=%b required 5 0 1", drop_cnt, repeat_cnt, rd_valid);
    end
  endtask

  task automatic test_slow_input();
    logic [1:0] exp_rd [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    do_reset(2);
    step(1'b1, 1'b0);
    idle(1);
    for (int p = 0; p < 4; p++) begin
      step(1'b1, 1'b0);
      idle(2);
      step(1'b0, 1'b1);
      idle(2);
      step(1'b0, 1'b1);
      checks++;
      if (rd_bank !== exp_rd[p] || repeat_cnt !== 8'(p + 1)) begin
        errors++;
        $display("FAIL slow_repeat[%0d] got rd=%0d rep=%0d required %0d %0d",
                 p, rd_bank, repeat_cnt, exp_rd[p], p + 1);
      end
      idle(2);
    end
    checks++;
    if (wr_bank !== 2'd1 || rd_bank !== 2'd0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL slow_final got wr=%0d rd=%0d drop=%0d required 1 0 0", wr_bank, rd_bank, drop_cnt);
    end
  endtask

  // Reaches wr=1, rd=0 with a pending frame, then fires both pulses together.
  task automatic test_simultaneous();
    step(1'b1, 1'b0);
    idle(1);
    step(1'b1, 1'b0);
    checks++;
    if (wr_bank !== 2'd1 || rd_bank !== 2'd0 || drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL simul_setup got wr=%0d rd=%0d drop=%0d required 1 0 1", wr_bank, rd_bank, drop_cnt);
    end
    idle(1);
    step(1'b1, 1'b1);
    checks++;
    if (rd_bank !== 2'd1 || wr_bank !== 2'd2 || drop_cnt !== 8'd2 ||
        rd_base !== 18'd76800 || wr_base !== 18'd153600 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL simul got rd=%0d wr=%0d drop=%0d rbase=%0d wbase=%0d rv=%b required 1 2 2 76800 153600 1",
               rd_bank, wr_bank, drop_cnt, rd_base, wr_base, rd_valid);
    end
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0);
      idle(1);
      step(1'b0, 1'b1);
      checks++;
      if (rd_bank !== 2'd1 || repeat_cnt !== 8'(5 + k)) begin
        errors++;
        $display("FAIL freeze_hold[%0d] got rd=%0d rep=%0d required 1 %0d", k, rd_bank, repeat_cnt, 5 + k);
      end
      idle(1);
    end
    freeze = 1'b0;
    step(1'b0, 1'b1);
    checks++;
    if (rd_bank !== 2'd0 || rd_base !== 18'd0 || wr_bank !== 2'd2 ||
        repeat_cnt !== 8'd8 || drop_cnt !== 8'd5) begin
      errors++;
      $display("FAIL unfreeze got rd=%0d rbase=%0d wr=%0d rep=%0d drop=%0d required 0 0 2 8 5",
               rd_bank, rd_base, wr_bank, repeat_cnt, drop_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    step(1'b1, 1'b0);
    idle(3);
    do_reset(1);
    check_reset_outputs("midframe_reset");
    // The frame in flight before reset must not become readable.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    checks++;
    if (rd_valid !== 1'b0 || rd_bank !== 2'd2 || wr_en_gate !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_read got rv=%b rd=%0d gate=%b required 0 2 1", rd_valid, rd_bank, wr_en_gate);
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_fast_input();
    test_slow_input();
    test_simultaneous();
    test_freeze();
    test_reset_midframe();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
